// File: rtl/nibble_sub_pkg.sv
// nibble_sub_pkg: shared state encoding, slice width and counter sizing for nibble_serial_sub.
package nibble_sub_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   localparam int SLICE_W = 4;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_sub_rbs_4.sv
// rbs_4: combinational 4-bit ripple-borrow subtractor, diff = a - b - bin.
module rbs_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] diff,
   output logic       bout
);

   logic [4:0] c;

   always_comb begin
      c    = '0;
      diff = '0;
      c[0] = bin;
      for (int i = 0; i < 4; i++) begin
         diff[i]  = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]);
      end
      bout = c[4];
   end

endmodule

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: multi-cycle a - b - bin, one 4-bit slice per clock behind start/ready/done.
// Define NIBBLE_SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_sub
   import nibble_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int N  = WIDTH / SLICE_W;
   localparam int CW = cnt_w(N);

   if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("nibble_serial_sub: WIDTH must be a positive multiple of 4");
   end

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
   logic             br;
   logic [CW-1:0]    cnt;
   logic [3:0]       s_d;
   logic             s_bo;
   logic             last;

   rbs_4 u_rbs (
      .a    (a_sh[3:0]),
      .b    (b_sh[3:0]),
      .bin  (br),
      .diff (s_d),
      .bout (s_bo)
   );

   // result nibbles enter at the MSB end so the final slice lands on top
   always_comb begin
      last      = (cnt == CW'(N - 1));
      res_nxt   = (WIDTH'(s_d) << (WIDTH - SLICE_W)) | (res_sh >> SLICE_W);
      state_nxt = (state == IDLE) ? (start ? RUN : IDLE) :
                  (state == RUN)  ? (last ? FIN : RUN)   : IDLE;
      ready     = (state == IDLE);
      done      = (state == FIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         borrow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
         end else if (state == RUN) begin
            a_sh   <= a_sh >> SLICE_W;
            b_sh   <= b_sh >> SLICE_W;
            res_sh <= res_nxt;
            br     <= s_bo;
            cnt    <= cnt + CW'(1);
            if (last) begin
               diff   <= res_nxt;
               borrow <= s_bo;
            end
         end
      end
   end

`ifdef NIBBLE_SERIAL_SUB_OVF_EN
   // during the final slice the low nibbles hold the operand sign bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf <= 1'b0;
      else if (state == RUN && last)
         ovf <= (a_sh[3] ^ b_sh[3]) & (s_d[3] ^ a_sh[3]);
   end
`endif

endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb_nibble_serial_sub: directed checks of nibble_serial_sub at WIDTH 8, 4 and 32.
module tb_nibble_serial_sub;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic       start = 1'b0, bin = 1'b0, ready, done, borrow;
   logic [7:0] a = '0, b = '0, diff;
   logic        start_4 = 1'b0, bin_4 = 1'b0, ready_4, done_4, borrow_4;
   logic [3:0]  a_4 = '0, b_4 = '0, diff_4;
   logic        start_32 = 1'b0, bin_32 = 1'b0, ready_32, done_32, borrow_32;
   logic [31:0] a_32 = '0, b_32 = '0, diff_32;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
   logic ovf, ovf_4, ovf_32;
`endif

   nibble_serial_sub #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .ready(ready), .done(done), .diff(diff), .borrow(borrow)
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
      , .ovf(ovf)
`endif
   );

   nibble_serial_sub #(.WIDTH(4)) dut_4 (
      .clk(clk), .rst_n(rst_n), .start(start_4), .a(a_4), .b(b_4), .bin(bin_4),
      .ready(ready_4), .done(done_4), .diff(diff_4), .borrow(borrow_4)
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
      , .ovf(ovf_4)
`endif
   );

   nibble_serial_sub #(.WIDTH(32)) dut_32 (
      .clk(clk), .rst_n(rst_n), .start(start_32), .a(a_32), .b(b_32), .bin(bin_32),
      .ready(ready_32), .done(done_32), .diff(diff_32), .borrow(borrow_32)
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
      , .ovf(ovf_32)
`endif
   );

   // one 8-bit operation: diff held while busy, done on the 3rd cycle after the start cycle
   task automatic op8(input logic [7:0] ta, input logic [7:0] tb2, input logic tbin,
                      input logic [7:0] ed, input logic eb, input string nm);
      logic [7:0] held;
      int lat;
      @(negedge clk);
      held = diff; a = ta; b = tb2; bin = tbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat = 1;
      while (!done && lat < 20) begin
         checks++;
         if (ready !== 1'b0 || diff !== held) begin
            failures++;
            $display("FAIL %s run: ready=%b diff=%h, need ready=0 diff=%h", nm, ready, diff, held);
         end
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== 3) begin
         failures++;
         $display("FAIL %s latency: got %0d cycles, need 3", nm, lat);
      end
      checks++;
      if (diff !== ed || borrow !== eb || ready !== 1'b0) begin
         failures++;
         $display("FAIL %s result: diff=%h borrow=%b ready=%b, need diff=%h borrow=%b ready=0",
                  nm, diff, borrow, ready, ed, eb);
      end
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || diff !== ed) begin
         failures++;
         $display("FAIL %s after: ready=%b done=%b diff=%h, need 1 0 %h", nm, ready, done, diff, ed);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ready, done, diff, borrow} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
         failures++;
         $display("FAIL reset8: ready=%b done=%b diff=%h borrow=%b, need 1 0 00 0", ready, done, diff, borrow);
      end
      checks++;
      if ({ready_4, done_4, diff_4, borrow_4, ready_32, done_32, diff_32, borrow_32}
          !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0}) begin
         failures++;
         $display("FAIL reset4_32: w4 %b%b %h %b w32 %b%b %h %b, need 10 0 0 / 10 0 0",
                  ready_4, done_4, diff_4, borrow_4, ready_32, done_32, diff_32, borrow_32);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "basic");
      op8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, "equal");
   endtask

   task automatic test_underflow();
      op8(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, "under");
      op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "bin_only");
      op8(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, "max_under");
   endtask

   task automatic test_busy();
      int n_done = 0;
      @(negedge clk);
      a = 8'h05; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 8'hFF; b = 8'h00;
      for (int c = 2; c <= 8; c++) begin
         @(negedge clk);
         if (done) n_done++;
         if (c == 3) begin
            checks++;
            if (done !== 1'b1 || diff !== 8'h04) begin
               failures++;
               $display("FAIL busy_result: done=%b diff=%h, need 1 04", done, diff);
            end
         end
         if (c == 4) start = 1'b0;
      end
      checks++;
      if (n_done !== 1 || ready !== 1'b1 || diff !== 8'h04) begin
         failures++;
         $display("FAIL busy_reject: dones=%0d ready=%b diff=%h, need 1 1 04", n_done, ready, diff);
      end
   endtask

   task automatic test_reset_mid();
      int n_done = 0;
      @(negedge clk);
      a = 8'h99; b = 8'h11; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ready, done, diff, borrow} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
         failures++;
         $display("FAIL reset_mid: ready=%b done=%b diff=%h borrow=%b, need 1 0 00 0", ready, done, diff, borrow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (done) n_done++;
      end
      checks++;
      if (n_done !== 0 || ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_idle: dones=%0d ready=%b, need 0 1", n_done, ready);
      end
      op8(8'h99, 8'h11, 1'b0, 8'h88, 1'b0, "after_rst");
   endtask

`ifdef NIBBLE_SERIAL_SUB_OVF_EN
   task automatic test_overflow();
      logic [7:0] ta [3] = '{8'h80, 8'h7F, 8'h05};
      logic [7:0] tb2[3] = '{8'h01, 8'hFF, 8'h03};
      logic [7:0] ed [3] = '{8'h7F, 8'h80, 8'h02};
      logic       eb [3] = '{1'b0, 1'b1, 1'b0};
      logic       eo [3] = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         op8(ta[i], tb2[i], 1'b0, ed[i], eb[i], "ovf_op");
         checks++;
         if (ovf !== eo[i]) begin
            failures++;
            $display("FAIL ovf%0d: ovf=%b, need %b", i, ovf, eo[i]);
         end
      end
   endtask
`endif

   task automatic test_sweep();
      logic [4:0]  m4;
      logic [32:0] m32;
      int l4, l32;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) begin
            a_4 = 4'h0; b_4 = 4'hF; bin_4 = 1'b1;
            a_32 = 32'h0; b_32 = 32'hFFFF_FFFF; bin_32 = 1'b1;
         end else begin
            a_4 = 4'($urandom); b_4 = 4'($urandom); bin_4 = 1'($urandom);
            a_32 = $urandom; b_32 = $urandom; bin_32 = 1'($urandom);
         end
         m4  = {1'b0, a_4} - {1'b0, b_4} - {4'b0, bin_4};
         m32 = {1'b0, a_32} - {1'b0, b_32} - {32'b0, bin_32};
         start_4 = 1'b1; start_32 = 1'b1;
         @(negedge clk);
         start_4 = 1'b0; start_32 = 1'b0;
         l4 = 0; l32 = 0;
         for (int c = 1; c <= 20; c++) begin
            if (done_4 && l4 == 0) l4 = c;
            if (done_32) begin
               l32 = c;
               break;
            end
            @(negedge clk);
         end
         checks++;
         if (l4 !== 2 || l32 !== 9) begin
            failures++;
            $display("FAIL sweep%0d latency: w4=%0d w32=%0d, need 2 9", i, l4, l32);
         end
         checks++;
         if (diff_4 !== m4[3:0] || borrow_4 !== m4[4]) begin
            failures++;
            $display("FAIL sweep%0d w4: diff=%h borrow=%b, need %h %b", i, diff_4, borrow_4, m4[3:0], m4[4]);
         end
         checks++;
         if (diff_32 !== m32[31:0] || borrow_32 !== m32[32]) begin
            failures++;
            $display("FAIL sweep%0d w32: diff=%h borrow=%b, need %h %b", i, diff_32, borrow_32, m32[31:0], m32[32]);
         end
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
         checks++;
         if (ovf_32 !== ((a_32[31] ^ b_32[31]) & (m32[31] ^ a_32[31]))) begin
            failures++;
            $display("FAIL sweep%0d ovf32: ovf=%b, need %b", i, ovf_32,
                     (a_32[31] ^ b_32[31]) & (m32[31] ^ a_32[31]));
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_busy();
      test_reset_mid();
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
      test_overflow();
`endif
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
